// File: rtl/ram_multi_read_port_clr.sv
// -----------------------------------------------------------------------------
// ram_multi_read_port_clr
//
// Purpose:
//   One-write / N-read synchronous RAM for register-file and scratch storage.
//   Features bit-masked writes, selectable read-during-write bypass, a
//   per-port read-valid flag, out-of-range protection on every port and a
//   hardware clear engine that zeroes the whole array on reset (optional)
//   or on request.
//
// Ports:
//   Clock          in   single clock, all state updates on the rising edge
//   Reset          in   synchronous, active-high; wins over every other input
//   iClear         in   pulse, starts a clear sweep (accepted in IDLE only)
//   iWriteEnable   in   write strobe
//   iWriteAddress  in   write address
//   iWriteMask     in   per-bit write enable, 1 = bit updated
//   iDataIn        in   write data
//   iReadEnable    in   per-port read strobe
//   iReadAddress   in   packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   oDataOut       out  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   oDataValid     out  port k oDataOut holds a fresh read result
//   oBusy          out  clear sweep in progress
// -----------------------------------------------------------------------------
module ram_multi_read_port_clr #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int MEM_SIZE       = 1024,
    parameter int READ_PORTS     = 2,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             iClear,
    input  logic                             iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
    input  logic [DATA_WIDTH-1:0]            iWriteMask,
    input  logic [DATA_WIDTH-1:0]            iDataIn,
    input  logic [READ_PORTS-1:0]            iReadEnable,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
    output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
    output logic [READ_PORTS-1:0]            oDataValid,
    output logic                             oBusy
);

    // Width of the physical array index; addresses are range-checked at full
    // width first, so only these low bits ever select a word.
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    // One extra bit so MEM_SIZE == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W   = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam bit                    RESET_CLEARS = (CLEAR_ON_RESET != 0);
    localparam bit                    BYPASS_EN    = (BYPASS != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = RESET_CLEARS ? ST_CLEAR : ST_IDLE;

    // Merge new data into an existing word under a per-bit mask.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    // True when an address selects a physically present word.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < MEM_SIZE_W);
    endfunction

    // -------------------------------------------------------------------------
    // Storage and control state
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]            mem_r [0:MEM_SIZE-1];
    state_t                           state_r;
    state_t                           state_nxt_s;
    logic [ADDR_WIDTH-1:0]            clr_cnt_r;
    logic [ADDR_WIDTH-1:0]            clr_cnt_nxt_s;
    logic                             busy_r;
    logic [READ_PORTS*DATA_WIDTH-1:0] data_out_r;
    logic [READ_PORTS-1:0]            data_valid_r;

    // -------------------------------------------------------------------------
    // Write path
    // -------------------------------------------------------------------------
    logic                  idle_s;
    logic                  wr_in_range_s;
    logic                  wr_commit_s;
    logic                  clr_commit_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [IDX_W-1:0]      clr_idx_s;
    logic [DATA_WIDTH-1:0] wr_old_s;
    logic [DATA_WIDTH-1:0] wr_merged_s;

    assign idle_s        = (state_r == ST_IDLE);
    assign wr_in_range_s = addr_in_range(iWriteAddress);
    assign wr_idx_s      = iWriteAddress[IDX_W-1:0];
    assign clr_idx_s     = clr_cnt_r[IDX_W-1:0];
    assign wr_old_s      = mem_r[wr_idx_s];
    assign wr_merged_s   = merge_word(wr_old_s, iDataIn, iWriteMask);

    // User writes only land in IDLE, in range, and never in a reset cycle.
    assign wr_commit_s  = !Reset && idle_s && iWriteEnable && wr_in_range_s;
    assign clr_commit_s = !Reset && (state_r == ST_CLEAR);

    // -------------------------------------------------------------------------
    // Clear FSM
    // -------------------------------------------------------------------------

    // Next-state and sweep-counter logic for the clear engine.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (iClear) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = clr_cnt_r;
                end
            end
            ST_CLEAR: begin
                // iClear is deliberately ignored while a sweep is running.
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // State, sweep counter and registered busy flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= RESET_STATE;
            clr_cnt_r <= {ADDR_WIDTH{1'b0}};
            busy_r    <= RESET_CLEARS;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            // Tracks the state register exactly, so it is high for MEM_SIZE cycles.
            busy_r    <= (state_nxt_s == ST_CLEAR);
        end
    end

    // Array update: the clear sweep has priority over user writes.
    always_ff @(posedge Clock) begin
        if (clr_commit_s) begin
            mem_r[clr_idx_s] <= {DATA_WIDTH{1'b0}};
        end else if (wr_commit_s) begin
            mem_r[wr_idx_s] <= wr_merged_s;
        end else begin
            mem_r[wr_idx_s] <= mem_r[wr_idx_s];
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word_s [READ_PORTS];

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] rd_addr_s;
        logic                  rd_in_range_s;
        logic                  rd_hit_s;

        assign rd_addr_s     = iReadAddress[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_in_range_s = addr_in_range(rd_addr_s);
        // Only a write that really commits this cycle can be forwarded.
        assign rd_hit_s      = BYPASS_EN && wr_commit_s && (rd_addr_s == iWriteAddress);

        assign rd_word_s[g] = !rd_in_range_s ? {DATA_WIDTH{1'b0}} :
                              rd_hit_s       ? wr_merged_s :
                                               mem_r[rd_addr_s[IDX_W-1:0]];
    end

    // Registered read data and valid flags; data holds whenever no fresh read.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_out_r   <= {(READ_PORTS*DATA_WIDTH){1'b0}};
            data_valid_r <= {READ_PORTS{1'b0}};
        end else if (!idle_s) begin
            data_out_r   <= data_out_r;
            data_valid_r <= {READ_PORTS{1'b0}};
        end else begin
            for (int k = 0; k < READ_PORTS; k++) begin
                data_valid_r[k] <= iReadEnable[k];
                if (iReadEnable[k]) begin
                    data_out_r[k*DATA_WIDTH +: DATA_WIDTH] <= rd_word_s[k];
                end else begin
                    data_out_r[k*DATA_WIDTH +: DATA_WIDTH] <= data_out_r[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign oDataOut   = data_out_r;
    assign oDataValid = data_valid_r;
    assign oBusy      = busy_r;

endmodule

// File: tb/tb_ram_multi_read_port_clr.sv
module tb_ram_multi_read_port_clr;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int MS = 16;
    localparam int RP = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iClear;
    logic          iWriteEnable;
    logic [AW-1:0] iWriteAddress;
    logic [DW-1:0] iWriteMask;
    logic [DW-1:0] iDataIn;
    logic [RP-1:0] iReadEnable;
    logic [RP*AW-1:0] iReadAddress;

    logic [RP*DW-1:0] dout_b1, dout_b0;
    logic [RP-1:0]    valid_b1, valid_b0;
    logic             busy_b1, busy_b0;

    always #5 Clock = ~Clock;

    ram_multi_read_port_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS),
        .READ_PORTS(RP), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iClear(iClear),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress),
        .iWriteMask(iWriteMask), .iDataIn(iDataIn),
        .iReadEnable(iReadEnable), .iReadAddress(iReadAddress),
        .oDataOut(dout_b1), .oDataValid(valid_b1), .oBusy(busy_b1)
    );

    ram_multi_read_port_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS),
        .READ_PORTS(RP), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) dut_nb (
        .Clock(Clock), .Reset(Reset), .iClear(iClear),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress),
        .iWriteMask(iWriteMask), .iDataIn(iDataIn),
        .iReadEnable(iReadEnable), .iReadAddress(iReadAddress),
        .oDataOut(dout_b0), .oDataValid(valid_b0), .oBusy(busy_b0)
    );

    typedef struct {
        logic          busy;
        logic [RP-1:0] valid;
        logic [31:0]   d1;
        logic [31:0]   d0;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [DW-1:0] m_mem [MS];
    logic [DW-1:0] m_d1 [RP];
    logic [DW-1:0] m_d0 [RP];
    logic [RP-1:0] m_valid;
    logic          m_busy;
    int            m_cnt;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp_v);
        end
    endtask

    // Predict next outputs from current inputs, clock once, compare.
    task automatic cyc();
        exp_t e;
        logic [AW-1:0] ra;
        logic [DW-1:0] old_w;
        logic          wr_ok;
        wr_ok = iWriteEnable && (iWriteAddress < AW'(MS));
        if (Reset) begin
            for (int k = 0; k < RP; k++) begin
                m_d1[k] = 8'h00;
                m_d0[k] = 8'h00;
            end
            m_valid = 4'b0000;
            m_busy  = 1'b1;
            m_cnt   = 0;
        end else if (m_busy) begin
            m_mem[m_cnt] = 8'h00;
            m_valid      = 4'b0000;
            if (m_cnt == MS - 1) m_busy = 1'b0;
            else m_cnt = m_cnt + 1;
        end else begin
            for (int k = 0; k < RP; k++) begin
                ra = iReadAddress[k*AW +: AW];
                m_valid[k] = iReadEnable[k];
                if (iReadEnable[k]) begin
                    if (ra < AW'(MS)) begin
                        old_w = m_mem[ra[3:0]];
                        m_d0[k] = old_w;
                        if (wr_ok && iWriteAddress == ra)
                            m_d1[k] = (old_w & ~iWriteMask) | (iDataIn & iWriteMask);
                        else
                            m_d1[k] = old_w;
                    end else begin
                        m_d1[k] = 8'h00;
                        m_d0[k] = 8'h00;
                    end
                end
            end
            if (wr_ok)
                m_mem[iWriteAddress[3:0]] = (m_mem[iWriteAddress[3:0]] & ~iWriteMask) | (iDataIn & iWriteMask);
            if (iClear) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        e.busy  = m_busy;
        e.valid = m_valid;
        e.d1    = {m_d1[3], m_d1[2], m_d1[1], m_d1[0]};
        e.d0    = {m_d0[3], m_d0[2], m_d0[1], m_d0[0]};
        sb.push_back(e);
        @(posedge Clock);
        #1;
        e = sb.pop_front();
        chk("busy_byp1",  {31'd0, busy_b1},  {31'd0, e.busy});
        chk("busy_byp0",  {31'd0, busy_b0},  {31'd0, e.busy});
        chk("valid_byp1", {28'd0, valid_b1}, {28'd0, e.valid});
        chk("valid_byp0", {28'd0, valid_b0}, {28'd0, e.valid});
        chk("data_byp1",  dout_b1, e.d1);
        chk("data_byp0",  dout_b0, e.d0);
    endtask

    task automatic idle_in();
        Reset         = 1'b0;
        iClear        = 1'b0;
        iWriteEnable  = 1'b0;
        iWriteAddress = 10'd0;
        iWriteMask    = 8'h00;
        iDataIn       = 8'h00;
        iReadEnable   = 4'b0000;
        iReadAddress  = 40'd0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        iWriteEnable  = 1'b1;
        iWriteAddress = a;
        iDataIn       = d;
        iWriteMask    = m;
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a);
        iReadEnable[k]          = 1'b1;
        iReadAddress[k*AW +: AW] = a;
    endtask

    task automatic read_all();
        for (int i = 0; i < MS / RP; i++) begin
            idle_in();
            for (int k = 0; k < RP; k++) rd(k, AW'(i * RP + k));
            cyc();
        end
        idle_in();
        cyc();
    endtask

    initial begin
        for (int i = 0; i < MS; i++) m_mem[i] = 8'h00;
        for (int k = 0; k < RP; k++) begin
            m_d1[k] = 8'h00;
            m_d0[k] = 8'h00;
        end
        m_valid = 4'b0000;
        m_busy  = 1'b0;
        m_cnt   = 0;

        // 1: reset-triggered clear, busy for MS cycles, then all zero
        idle_in();
        Reset = 1'b1;
        cyc();
        idle_in();
        repeat (MS + 2) cyc();
        read_all();

        // 2: full-mask write then two-port read of the same word
        wr(10'd3, 8'hA5, 8'hFF);
        cyc();
        idle_in();
        rd(0, 10'd3);
        rd(1, 10'd3);
        cyc();
        idle_in();
        cyc();

        // 3: masked read-during-write, bypass vs old data
        wr(10'd5, 8'hFF, 8'hFF);
        cyc();
        idle_in();
        wr(10'd5, 8'h00, 8'h0F);
        rd(0, 10'd5);
        cyc();
        idle_in();
        rd(0, 10'd5);
        rd(3, 10'd5);
        cyc();

        // zero mask write leaves the word alone, bypass sees old word
        idle_in();
        wr(10'd3, 8'h00, 8'h00);
        rd(2, 10'd3);
        cyc();
        idle_in();
        rd(1, 10'd3);
        cyc();

        // 4: out-of-range write dropped (no aliasing to addr 4), read returns 0
        idle_in();
        wr(10'd20, 8'h5A, 8'hFF);
        rd(2, 10'd20);
        cyc();
        idle_in();
        rd(0, 10'd4);
        rd(2, 10'd20);
        rd(3, 10'd1023);
        cyc();

        // 6: four ports read distinct addresses, then partial enables hold data
        for (int i = 0; i < RP; i++) begin
            idle_in();
            wr(AW'(8 + i), DW'(8'h10 * (i + 1) + i), 8'hFF);
            cyc();
        end
        idle_in();
        for (int k = 0; k < RP; k++) rd(k, AW'(11 - k));
        cyc();
        idle_in();
        rd(0, 10'd3);
        rd(2, 10'd5);
        cyc();
        idle_in();
        cyc();

        // 5a: requested clear; reads and a write issued mid-sweep are dropped
        iClear = 1'b1;
        cyc();
        idle_in();
        iClear = 1'b1;
        rd(1, 10'd9);
        cyc();
        idle_in();
        repeat (12) cyc();
        wr(10'd2, 8'h77, 8'hFF);
        rd(0, 10'd2);
        cyc();
        idle_in();
        repeat (4) cyc();
        read_all();

        // 5: clear, write during sweep, reset at sweep cycle 7 restarts sweep
        wr(10'd6, 8'h3C, 8'hFF);
        cyc();
        idle_in();
        iClear = 1'b1;
        cyc();
        idle_in();
        repeat (3) cyc();
        wr(10'd12, 8'hC3, 8'hFF);
        cyc();
        idle_in();
        repeat (3) cyc();
        Reset = 1'b1;
        cyc();
        idle_in();
        repeat (MS + 1) cyc();
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
